// File: rtl/riffa_chnl_exerciser_if.sv
// Channel bundle between the RIFFA core side (master) and channel user logic (slave).
interface riffa_chnl_exerciser_if #(
    parameter int C_PCI_DATA_WIDTH = 32
);
    logic                        CHNL_RX_CLK;
    logic                        CHNL_RX;
    logic                        CHNL_RX_ACK;
    logic                        CHNL_RX_LAST;
    logic [31:0]                 CHNL_RX_LEN;
    logic [30:0]                 CHNL_RX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
    logic                        CHNL_RX_DATA_VALID;
    logic                        CHNL_RX_DATA_REN;

    logic                        CHNL_TX_CLK;
    logic                        CHNL_TX;
    logic                        CHNL_TX_ACK;
    logic                        CHNL_TX_LAST;
    logic [31:0]                 CHNL_TX_LEN;
    logic [30:0]                 CHNL_TX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
    logic                        CHNL_TX_DATA_VALID;
    logic                        CHNL_TX_DATA_REN;

    modport master (
        input  CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
        output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        input  CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA,
               CHNL_TX_DATA_VALID,
        output CHNL_TX_ACK, CHNL_TX_DATA_REN
    );

    modport slave (
        output CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
        input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        output CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_DATA,
               CHNL_TX_DATA_VALID,
        input  CHNL_TX_ACK, CHNL_TX_DATA_REN
    );
endinterface

// File: rtl/riffa_chnl_exerciser.sv
// On-chip stand-in for the RIFFA core side of one channel. Sends a counting
// pattern on RX and checks the words returned on TX.
// Optional watchdog: define RIFFA_EXER_TIMEOUT_EN to enable the idle timeout (ERR[2]).
//
// Send FSM     state  | meaning
//              S_IDLE | no test running
//              S_REQ  | CHNL_RX raised, waiting for CHNL_RX_ACK
//              S_DATA | streaming pattern beats
//              S_FIN  | all beats accepted, waiting for receive side
// Receive FSM  R_IDLE | waiting for CHNL_TX while busy
//              R_ACK  | CHNL_TX_ACK pulse, length compare
//              R_DATA | consuming and checking returned beats
//              R_FIN  | all words received, waiting for send side
module riffa_chnl_exerciser #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT        = 65535
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [31:0] LEN_IN,
    input  logic [31:0] SEED,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  ERR,
    output logic [15:0] ERR_COUNT,
    riffa_chnl_exerciser_if.master chnl
);
    localparam int          L  = C_PCI_DATA_WIDTH / 32;
    localparam logic [31:0] LW = 32'(L);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_FIN} snd_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA, R_FIN} rcv_t;

    snd_t        r_snd;
    rcv_t        r_rcv;
    logic        r_busy, r_done;
    logic [2:0]  r_err;
    logic [15:0] r_err_cnt;
    logic [31:0] r_len, r_seed, r_sent, r_tx_len, r_rcvd;
    logic        r_rx, r_rx_valid, r_tx_ack, r_tx_ren;

    logic                        w_start, w_rx_hs, w_tx_hs, w_rx_last, w_tx_last;
    logic                        w_finish, w_timeout, w_abort, w_mismatch;
    logic [31:0]                 w_rx_rem, w_tx_rem;
    logic [C_PCI_DATA_WIDTH-1:0] w_rx_data;

    assign w_start   = START & ~r_busy;
    assign w_rx_hs   = r_rx_valid & chnl.CHNL_RX_DATA_REN;
    assign w_tx_hs   = r_tx_ren & chnl.CHNL_TX_DATA_VALID;
    // Remaining counts are differences, so a length near 2^32 never wraps the compare.
    assign w_rx_rem  = r_len - r_sent;
    assign w_tx_rem  = r_tx_len - r_rcvd;
    assign w_rx_last = (w_rx_rem <= LW);
    assign w_tx_last = (w_tx_rem <= LW);
    assign w_finish  = (r_snd == S_FIN) && (r_rcv == R_FIN);
    assign w_abort   = w_finish | w_timeout;

`ifdef RIFFA_EXER_TIMEOUT_EN
    logic [31:0] r_wdog;

    // Watchdog: reloads on any beat handshake or while idle, fires at zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_wdog <= 32'(C_TIMEOUT);
        else if (!r_busy || w_rx_hs || w_tx_hs)
            r_wdog <= 32'(C_TIMEOUT);
        else if (r_wdog != 32'd0)
            r_wdog <= r_wdog - 32'd1;
    end

    assign w_timeout = r_busy && (r_wdog == 32'd0);
`else
    assign w_timeout = 1'b0;
`endif

    // Pattern lanes for the current RX beat and mismatch detection on the TX beat.
    always_comb begin
        w_rx_data  = '0;
        w_mismatch = 1'b0;
        for (int j = 0; j < L; j++) begin
            if (r_rx_valid && (32'(j) < w_rx_rem))
                w_rx_data[j*32 +: 32] = r_seed + r_sent + 32'(j);
            if ((32'(j) < w_tx_rem) &&
                (chnl.CHNL_TX_DATA[j*32 +: 32] != (r_seed + r_rcvd + 32'(j))))
                w_mismatch = 1'b1;
        end
    end

    // Test control: start latching, completion, sticky error flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 3'b000;
            r_err_cnt <= 16'd0;
            r_len     <= 32'd0;
            r_seed    <= 32'd0;
        end else if (w_start) begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 3'b000;
            r_err_cnt <= 16'd0;
            r_len     <= LEN_IN;
            r_seed    <= SEED;
        end else if (r_busy && w_abort) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            if (w_timeout)
                r_err[2] <= 1'b1;
        end else if (r_busy) begin
            if ((r_rcv == R_ACK) && (r_tx_len != r_len))
                r_err[1] <= 1'b1;
            if (w_tx_hs && w_mismatch) begin
                r_err[0] <= 1'b1;
                if (r_err_cnt != 16'hFFFF)
                    r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    // Send FSM: request, stream pattern beats, then hold in FIN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_snd      <= S_IDLE;
            r_rx       <= 1'b0;
            r_rx_valid <= 1'b0;
            r_sent     <= 32'd0;
        end else if (w_abort) begin
            r_snd      <= S_IDLE;
            r_rx       <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            case (r_snd)
                S_IDLE: if (w_start) begin
                    r_snd  <= S_REQ;
                    r_rx   <= 1'b1;
                    r_sent <= 32'd0;
                end
                S_REQ: if (chnl.CHNL_RX_ACK) begin
                    if (r_len == 32'd0) begin
                        r_rx  <= 1'b0;
                        r_snd <= S_FIN;
                    end else begin
                        r_rx_valid <= 1'b1;
                        r_snd      <= S_DATA;
                    end
                end
                S_DATA: if (w_rx_hs) begin
                    r_sent <= r_sent + LW;
                    if (w_rx_last) begin
                        r_rx       <= 1'b0;
                        r_rx_valid <= 1'b0;
                        r_snd      <= S_FIN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Receive FSM: acknowledge TX, consume and check beats, then hold in FIN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rcv    <= R_IDLE;
            r_tx_ack <= 1'b0;
            r_tx_ren <= 1'b0;
            r_tx_len <= 32'd0;
            r_rcvd   <= 32'd0;
        end else if (w_abort) begin
            r_rcv    <= R_IDLE;
            r_tx_ack <= 1'b0;
            r_tx_ren <= 1'b0;
        end else begin
            case (r_rcv)
                R_IDLE: if (r_busy && chnl.CHNL_TX) begin
                    r_tx_len <= chnl.CHNL_TX_LEN;
                    r_rcvd   <= 32'd0;
                    r_tx_ack <= 1'b1;
                    r_rcv    <= R_ACK;
                end
                R_ACK: begin
                    r_tx_ack <= 1'b0;
                    if (r_tx_len == 32'd0) begin
                        r_rcv <= R_FIN;
                    end else begin
                        r_tx_ren <= 1'b1;
                        r_rcv    <= R_DATA;
                    end
                end
                R_DATA: if (w_tx_hs) begin
                    r_rcvd <= r_rcvd + LW;
                    if (w_tx_last) begin
                        r_tx_ren <= 1'b0;
                        r_rcv    <= R_FIN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign ERR       = r_err;
    assign ERR_COUNT = r_err_cnt;

    assign chnl.CHNL_RX            = r_rx;
    assign chnl.CHNL_RX_LAST       = 1'b1;
    assign chnl.CHNL_RX_LEN        = r_len;
    assign chnl.CHNL_RX_OFF        = 31'd0;
    assign chnl.CHNL_RX_DATA       = w_rx_data;
    assign chnl.CHNL_RX_DATA_VALID = r_rx_valid;
    assign chnl.CHNL_TX_ACK        = r_tx_ack;
    assign chnl.CHNL_TX_DATA_REN   = r_tx_ren;

    // Single-clock design: channel clocks, TX_LAST and TX_OFF carry no information here.
    wire w_unused_ok = &{1'b0, chnl.CHNL_RX_CLK, chnl.CHNL_TX_CLK, chnl.CHNL_TX_LAST,
                         chnl.CHNL_TX_OFF};
endmodule

// File: doc/riffa_chnl_exerciser.md
Name: riffa_chnl_exerciser

Overview:
- Synthesizable on-chip stand-in for the RIFFA core side of one channel, for self-test of channel user logic without a host.
- Acts as the opposite end of the channel interface. It drives CHNL_RX transactions (host-to-FPGA) carrying a counting pattern, and accepts CHNL_TX transactions (FPGA-to-host), checking their length and data.
- Sits where the RIFFA endpoint would connect to a channel module; started and monitored by a small control/status harness.

Parameters:
- C_PCI_DATA_WIDTH, 32, channel data width in bits; one of 32/64/128; lanes per beat L = C_PCI_DATA_WIDTH/32.
- C_TIMEOUT, 65535, idle-cycle watchdog limit; used only with the optional feature.

Ports:
- CLK  in  1  sole clock; all logic on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; begins a test when idle.
- LEN_IN  in  32  RX transfer length in 32-bit words; sampled on START.
- SEED  in  32  pattern base; sampled on START.
- BUSY  out  1  test in progress.
- DONE  out  1  sticky; both directions complete.
- ERR  out  3  sticky: [0] data mismatch, [1] TX length mismatch, [2] timeout.
- ERR_COUNT  out  16  data-mismatch beats; saturates at 16'hFFFF.
- CHNL_RX_CLK  in  1  from user logic; unused (single clock).
- CHNL_RX  out  1  RX transaction request.
- CHNL_RX_ACK  in  1  user logic accepts RX.
- CHNL_RX_LAST  out  1  constant 1.
- CHNL_RX_LEN  out  32  latched LEN_IN.
- CHNL_RX_OFF  out  31  constant 0.
- CHNL_RX_DATA  out  C_PCI_DATA_WIDTH  pattern beat.
- CHNL_RX_DATA_VALID  out  1  beat valid.
- CHNL_RX_DATA_REN  in  1  user logic consumes beat.
- CHNL_TX_CLK  in  1  unused.
- CHNL_TX  in  1  TX transaction request.
- CHNL_TX_ACK  out  1  acceptance pulse.
- CHNL_TX_LAST  in  1  ignored.
- CHNL_TX_LEN  in  32  TX length in words.
- CHNL_TX_OFF  in  31  ignored.
- CHNL_TX_DATA  in  C_PCI_DATA_WIDTH  returned data.
- CHNL_TX_DATA_VALID  in  1  beat valid.
- CHNL_TX_DATA_REN  out  1  exerciser consumes beat.

Behaviour:
- Reset (RST_N=0, async): all outputs 0 except CHNL_RX_LAST=1; both FSMs return to IDLE; counters, errors and ERR_COUNT are cleared. Reset mid-transfer abandons the transfer immediately.
- START while idle: latch LEN_IN/SEED; clear DONE, ERR and ERR_COUNT; BUSY=1 from the next cycle. START while BUSY=1 is ignored.
- Send FSM states: IDLE, REQ, DATA, FIN.
  - REQ: CHNL_RX=1 until CHNL_RX_ACK is sampled high, then go to DATA. CHNL_RX stays 1 through DATA.
  - DATA: CHNL_RX_DATA_VALID=1 while beats remain. A beat advances only on VALID&REN.
  - Lane j of beat b carries SEED+b*L+j (mod 2^32).
  - Beats = ceil(LEN/L). Lanes beyond LEN in the final beat carry 0.
  - After the final accepted beat, CHNL_RX and VALID deassert in the same cycle; go to FIN.
  - LEN=0: skip DATA after ACK and go straight to FIN.
- Receive FSM states: IDLE, ACK, DATA, FIN. It runs independently, and TX may arrive before the send side finishes.
  - In IDLE with BUSY=1 and CHNL_TX=1: latch CHNL_TX_LEN; pulse CHNL_TX_ACK for exactly 1 cycle; go to DATA.
  - In DATA: CHNL_TX_DATA_REN=1 while received words < latched TX length.
  - On VALID&REN, compare each lane j < remaining against SEED+rx_words+j. A beat with any mismatch sets ERR[0] and increments ERR_COUNT by 1.
  - Leave DATA when received words >= TX length.
  - If latched TX length != LEN, set ERR[1]; the data check then covers min(TX length, received) words.
- Completion: when both FSMs are in FIN, DONE=1 and BUSY=0 on the next cycle, and both FSMs return to IDLE.
- Arithmetic: word counters are 32 bits. Remaining-lane masks are computed from count differences, so there is no wraparound for LEN up to 2^32-L.

Optional Feature:
- Macro RIFFA_EXER_TIMEOUT_EN.
- Defined: a 32-bit watchdog counts cycles with BUSY=1 and no RX or TX beat handshake, clearing on any handshake. When the count reaches C_TIMEOUT: set ERR[2]; drop CHNL_RX, VALID and REN; force DONE=1 and BUSY=0.
- Undefined: no watchdog; ERR[2] is tied to 0.

Test Plan:
- Ideal loopback (user logic echoes immediately, REN/VALID always 1), W=32, LEN=8, SEED=0x100 -> RX beats 0x100..0x107; TX accepted; DONE=1, ERR=0, ERR_COUNT=0.
- W=64, LEN=5, random REN and VALID stalls -> 3 RX beats, last upper lane=0; exact 5 words checked; ERR=0.
- Echo returns word 3 corrupted, LEN=8 -> ERR[0]=1, ERR_COUNT=1, DONE=1.
- User logic returns TX_LEN=6 for LEN=8 -> ERR[1]=1; 6 words checked, DONE=1.
- START pulsed again mid-transfer -> ignored; RST_N low during DATA -> all outputs at reset values the same cycle; a later START runs cleanly.
- With RIFFA_EXER_TIMEOUT_EN, C_TIMEOUT=100, CHNL_RX_ACK never asserted -> ERR[2]=1 and DONE=1 after 100 cycles; without the macro, BUSY stays 1.
